// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32I R-type datapath.
// Fetches over a req/ack handshake with a bounded wait, traps on bad encodings or bus timeout.
module multicycle_control_unit #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int RETIRE_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                imemReq,
    input  logic                imemAck,
    input  logic [31:0]         imemData,
    output logic [31:0]         instrCode,
    output logic [3:0]          aluControl,
    output logic                regFileWe,
    output logic                pcEn,
    output logic                aluLatchEn,
    output logic                busy,
    output logic                illegalInstr,
    output logic                busError,
    output logic [RETIRE_W-1:0] retireCount
);

    localparam int CW = $clog2(FETCH_TIMEOUT) + 1;
    localparam logic [CW-1:0] TMAX = CW'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_tcnt;
    logic [31:0]         r_instr;
    logic [3:0]          r_alu;
    logic                r_ill;
    logic                r_berr;
    logic [RETIRE_W-1:0] r_retire;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_alt;
    logic       w_legal;
    logic [3:0] w_alu_op;

    assign w_opc = r_instr[6:0];
    assign w_f3  = r_instr[14:12];
    assign w_f7  = r_instr[31:25];
    assign w_alt = (w_f7 == 7'b0100000);

    // The alternate funct7 only exists for SUB and SRA.
    assign w_legal = (w_opc == 7'b0110011) &&
                     ((w_f7 == 7'b0000000) ||
                      (w_alt && (w_f3 == 3'b000 || w_f3 == 3'b101)));

    always_comb begin
        w_alu_op = 4'b0000;
        case (w_f3)
            3'b000:  w_alu_op = w_alt ? 4'b0001 : 4'b0000;
            3'b001:  w_alu_op = 4'b0010;
            3'b101:  w_alu_op = w_alt ? 4'b0100 : 4'b0011;
            3'b010:  w_alu_op = 4'b0101;
            3'b011:  w_alu_op = 4'b0110;
            3'b100:  w_alu_op = 4'b0111;
            3'b110:  w_alu_op = 4'b1000;
            3'b111:  w_alu_op = 4'b1001;
            default: w_alu_op = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_tcnt   <= '0;
            r_instr  <= '0;
            r_alu    <= 4'b0000;
            r_ill    <= 1'b0;
            r_berr   <= 1'b0;
            r_retire <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_tcnt  <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imemAck) begin
                        r_instr <= imemData;
                        r_tcnt  <= '0;
                        r_state <= S_DECODE;
                    end else if (r_tcnt == TMAX) begin
                        r_berr  <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= S_TRAP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_alu   <= w_alu_op;
                        r_state <= S_EXECUTE;
                    end else begin
                        r_ill   <= 1'b1;
                        r_state <= S_TRAP;
                    end
                end
                S_EXECUTE: r_state <= S_WRITEBACK;
                S_WRITEBACK: begin
                    r_retire <= r_retire + 1'b1;
                    r_state  <= run ? S_FETCH : S_IDLE;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imemReq      = (r_state == S_FETCH);
    assign aluLatchEn   = (r_state == S_EXECUTE);
    assign pcEn         = (r_state == S_WRITEBACK);
    assign regFileWe    = (r_state == S_WRITEBACK) && (r_instr[11:7] != 5'd0);
    assign busy         = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                          (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
    assign instrCode    = r_instr;
    assign aluControl   = r_alu;
    assign illegalInstr = r_ill;
    assign busError     = r_berr;
    assign retireCount  = r_retire;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a tiny register-file/ALU datapath model.
// A second 2-bit-counter instance shares the stimulus to exercise counter wrap.
module tb_multicycle_control_unit;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRA   = 32'h407352B3;
    localparam logic [31:0] I_ADDX0 = 32'h00208033;
    localparam logic [31:0] I_ADDI  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;

    logic        imemReq, regFileWe, pcEn, aluLatchEn, busy, illegalInstr, busError;
    logic [31:0] instrCode;
    logic [3:0]  aluControl;
    logic [31:0] retireCount;

    logic        w2_req, w2_we, w2_pc, w2_lat, w2_busy, w2_ill, w2_berr;
    logic [31:0] w2_instr;
    logic [3:0]  w2_alu;
    logic [1:0]  w2_retire;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.FETCH_TIMEOUT(16), .RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imemReq(imemReq), .imemAck(imemAck), .imemData(imemData),
        .instrCode(instrCode), .aluControl(aluControl),
        .regFileWe(regFileWe), .pcEn(pcEn), .aluLatchEn(aluLatchEn),
        .busy(busy), .illegalInstr(illegalInstr), .busError(busError),
        .retireCount(retireCount)
    );

    multicycle_control_unit #(.FETCH_TIMEOUT(16), .RETIRE_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .run(run),
        .imemReq(w2_req), .imemAck(imemAck), .imemData(imemData),
        .instrCode(w2_instr), .aluControl(w2_alu),
        .regFileWe(w2_we), .pcEn(w2_pc), .aluLatchEn(w2_lat),
        .busy(w2_busy), .illegalInstr(w2_ill), .busError(w2_berr),
        .retireCount(w2_retire)
    );

    logic [31:0] rf [32];
    logic [31:0] alu_q;

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return a >> b[4:0];
            4'd4: return $unsigned($signed(a) >>> b[4:0]);
            4'd5: return {31'd0, $signed(a) < $signed(b)};
            4'd6: return {31'd0, a < b};
            4'd7: return a ^ b;
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i + 1);
            alu_q <= '0;
        end else begin
            if (aluLatchEn)
                alu_q <= alu_f(aluControl, rf[instrCode[19:15]], rf[instrCode[24:20]]);
            if (regFileWe)
                rf[instrCode[11:7]] <= alu_q;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        imemAck = 1'b0;
        imemData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b0;
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADD;
        repeat (2) @(negedge clk);
        got = {imemReq, regFileWe, pcEn, aluLatchEn, busy, illegalInstr, busError, 1'b0};
        n_total++;
        if (got !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000", got);
        else n_pass++;
        n_total++;
        if ({instrCode, aluControl, retireCount} !== 68'd0)
            $display("FAIL reset_regs: instr %h alu %h ret %0d want 0", instrCode, aluControl, retireCount);
        else n_pass++;
        run = 1'b0;
        imemAck = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_add_stream();
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADD;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_total++;
            if (pcEn !== (k % 4 == 0) || regFileWe !== (k % 4 == 0))
                $display("FAIL add_pulse[%0d]: pcEn %b we %b want %b", k, pcEn, regFileWe, k % 4 == 0);
            else n_pass++;
            if (k == 12) run = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (retireCount !== 32'd3 || aluControl !== 4'b0000)
            $display("FAIL add_retire: ret %0d alu %b want 3 0000", retireCount, aluControl);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || imemReq !== 1'b0 || w2_retire !== 2'd3)
            $display("FAIL add_idle: busy %b req %b wret %0d want 0 0 3", busy, imemReq, w2_retire);
        else n_pass++;
    endtask

    task automatic test_sub_sra();
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_SUB;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2) imemData = I_SRA;
            if (k == 3) begin
                n_total++;
                if (aluControl !== 4'b0001 || aluLatchEn !== 1'b1)
                    $display("FAIL sub_alu: alu %b lat %b want 0001 1", aluControl, aluLatchEn);
                else n_pass++;
            end
            if (k == 7) begin
                n_total++;
                if (aluControl !== 4'b0100)
                    $display("FAIL sra_alu: alu %b want 0100", aluControl);
                else n_pass++;
            end
            if (k == 8) run = 1'b0;
        end
        n_total++;
        if (rf[3] !== 32'hFFFF_FFFF)
            $display("FAIL sub_x3: got %h want ffffffff", rf[3]);
        else n_pass++;
        n_total++;
        if (rf[5] !== 32'h0 || retireCount !== 32'd2)
            $display("FAIL sra_x5: x5 %h ret %0d want 0 2", rf[5], retireCount);
        else n_pass++;
    endtask

    task automatic test_rd_x0();
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADDX0;
        repeat (4) @(negedge clk);
        n_total++;
        if (pcEn !== 1'b1 || regFileWe !== 1'b0)
            $display("FAIL x0_wb: pcEn %b we %b want 1 0", pcEn, regFileWe);
        else n_pass++;
        run = 1'b0;
        @(negedge clk);
        n_total++;
        if (retireCount !== 32'd1 || busy !== 1'b0)
            $display("FAIL x0_retire: ret %0d busy %b want 1 0", retireCount, busy);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic seen_pc;
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADDI;
        seen_pc = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (illegalInstr !== 1'b0 || busy !== 1'b1)
            $display("FAIL ill_decode: ill %b busy %b want 0 1", illegalInstr, busy);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pcEn || regFileWe) seen_pc = 1'b1;
        end
        n_total++;
        if (seen_pc !== 1'b0)
            $display("FAIL ill_nopc: got %b want 0", seen_pc);
        else n_pass++;
        n_total++;
        if ({illegalInstr, busy, imemReq, busError} !== 4'b1000 ||
            retireCount !== 32'd0 || aluControl !== 4'b0000)
            $display("FAIL ill_trap: flags %b ret %0d alu %b want 1000 0 0000",
                     {illegalInstr, busy, imemReq, busError}, retireCount, aluControl);
        else n_pass++;
    endtask

    task automatic test_timeout_ok();
        do_reset();
        run = 1'b1;
        imemAck = 1'b0;
        imemData = I_ADD;
        repeat (16) @(negedge clk);
        n_total++;
        if (imemReq !== 1'b1 || busError !== 1'b0)
            $display("FAIL tmo_last: req %b berr %b want 1 0", imemReq, busError);
        else n_pass++;
        imemAck = 1'b1;
        @(negedge clk);
        imemAck = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (pcEn !== 1'b1 || busError !== 1'b0)
            $display("FAIL tmo_wb: pcEn %b berr %b want 1 0", pcEn, busError);
        else n_pass++;
        run = 1'b0;
        @(negedge clk);
        n_total++;
        if (retireCount !== 32'd1)
            $display("FAIL tmo_retire: got %0d want 1", retireCount);
        else n_pass++;
    endtask

    task automatic test_timeout_fail();
        do_reset();
        run = 1'b1;
        imemAck = 1'b0;
        repeat (16) @(negedge clk);
        n_total++;
        if (busError !== 1'b0 || imemReq !== 1'b1)
            $display("FAIL berr_early: berr %b req %b want 0 1", busError, imemReq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busError, busy, imemReq, illegalInstr} !== 4'b1000 || retireCount !== 32'd0)
            $display("FAIL berr_trap: flags %b ret %0d want 1000 0",
                     {busError, busy, imemReq, illegalInstr}, retireCount);
        else n_pass++;
    endtask

    task automatic test_run_drop();
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADD;
        repeat (3) @(negedge clk);
        n_total++;
        if (aluLatchEn !== 1'b1)
            $display("FAIL drop_exec: lat %b want 1", aluLatchEn);
        else n_pass++;
        run = 1'b0;
        @(negedge clk);
        n_total++;
        if (pcEn !== 1'b1)
            $display("FAIL drop_wb: pcEn %b want 1", pcEn);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (imemReq !== 1'b0 || busy !== 1'b0 || retireCount !== 32'd1)
            $display("FAIL drop_idle: req %b busy %b ret %0d want 0 0 1", imemReq, busy, retireCount);
        else n_pass++;
    endtask

    task automatic test_reset_exec();
        logic seen_we;
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADD;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({imemReq, regFileWe, pcEn, aluLatchEn, busy} !== 5'b0 ||
            instrCode !== 32'd0 || retireCount !== 32'd0)
            $display("FAIL rst_exec: flags %b instr %h ret %0d want 0",
                     {imemReq, regFileWe, pcEn, aluLatchEn, busy}, instrCode, retireCount);
        else n_pass++;
        seen_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (regFileWe || pcEn) seen_we = 1'b1;
        end
        n_total++;
        if (seen_we !== 1'b0)
            $display("FAIL rst_nowe: got %b want 0", seen_we);
        else n_pass++;
        run = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run = 1'b1;
        imemAck = 1'b1;
        imemData = I_ADD;
        repeat (16) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        n_total++;
        if (retireCount !== 32'd4 || w2_retire !== 2'd0)
            $display("FAIL wrap: ret %0d wret %0d want 4 0", retireCount, w2_retire);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_stream();
        test_sub_sra();
        test_rd_x0();
        test_illegal();
        test_timeout_ok();
        test_timeout_fail();
        test_run_drop();
        test_reset_exec();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
